fakeram7_dp_512x32_ctrl: RTL and testbench
==========================================

// Module: fakeram7_dp_512x32_ctrl
// PURPOSE
//  Request-side controller feeding the fakeram7_dp_512x32 dual-port macro. It turns two valid/ready request channels (A, B) into macro pin activity.
//  It expands byte strobes to bit masks, arbitrates same-address conflicts, and captures 1-cycle read data into per-port response FIFOs under backpressure.
// PARAMETERS
//  BITS        32   data width; must be a multiple of 8
//  WORD_DEPTH  512  macro words
//  ADDR_WIDTH  9    clog2(WORD_DEPTH)
//  RSP_DEPTH   3    response FIFO entries per port; 3 gives 1 read/cycle/port
// PORTS
//  clk              in   1           single clock, also drives macro clk
//  rst_n            in   1           asynchronous active-low reset
//  req_valid_{A,B}  in   1           request valid
//  req_ready_{A,B}  out  1           request accepted when valid&ready
//  req_we_{A,B}     in   1           1=write, 0=read
//  req_addr_{A,B}   in   ADDR_WIDTH  word address
//  req_wdata_{A,B}  in   BITS        write data
//  req_wstrb_{A,B}  in   BITS/8      byte enables; bit i covers data[8i+7:8i]
//  rsp_valid_{A,B}  out  1           read data available
//  rsp_ready_{A,B}  in   1           consumer pops on valid&ready
//  rsp_rdata_{A,B}  out  BITS        read data, FIFO head
//  ram_ce_in        out  1           macro chip enable
//  ram_we_in_{A,B}  out  1           macro write enables
//  ram_addr_in_{A,B} out ADDR_WIDTH  macro addresses
//  ram_wd_in_{A,B}  out  BITS        macro write data
//  ram_w_mask_in_{A,B} out BITS      macro bit masks
//  ram_rd_out_{A,B} in   BITS        macro registered read data
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFOs emptied, in-flight reads dropped, rsp_valid_*=0, ram_ce_in=0, all ram_* buses 0.
//  - acc_X = req_valid_X & req_ready_X. Macro pins are combinational from the accepted request:
//    ram_ce_in = acc_A|acc_B; ram_we_in_X = acc_X&req_we_X; ram_addr/wd = request fields when acc_X, else 0;
//    ram_w_mask_in_X = {8{wstrb[i]}} per byte when writing, else 0. A write with wstrb==0 still occupies a cycle and writes nothing.
//  - Credits: cnt_X = FIFO occupancy + in-flight read (0..RSP_DEPTH). A read is accepted only if cnt_X<RSP_DEPTH. Writes need no credit and produce no response.
//  - Read latency: read accepted in cycle N -> macro registers data at edge N -> rd_pend_X set.
//    In cycle N+1 ram_rd_out_X is pushed into FIFO X at the N+1 edge -> rsp_valid_X=1 in cycle N+2.
//    ram_rd_out_X is sampled only when rd_pend_X=1 (ce is shared, other cycles are don't-care).
//  - Collision: acc_A & req_valid_B & addr_A==addr_B & (we_A|we_B) -> req_ready_B=0 this cycle; A has strict priority.
//    Two reads to the same address are both accepted. req_ready_B may depend combinationally on port-A inputs; req_ready_A never depends on port B.
//  - req_ready_X never depends on rsp_ready_X (no comb path rsp->req). Pop and push in the same cycle keep cnt unchanged.
//  - FIFO order is strictly per-port in-order. No ordering across ports.
//  - Counter width clog2(RSP_DEPTH+1); cnt never exceeds RSP_DEPTH or underflows (assert).
//  - Reset mid-read: the pending read is discarded; no response appears after release.
// STRUCTURE
//  - Shared package fakeram7_ctrl_pkg: strb2mask function, RSP_CNT_W computation.
//  - Sub-module fakeram7_rsp_fifo (BITS, RSP_DEPTH; push/pop/full/empty/count), instantiated once per port.
//  - Top level: credit logic, collision compare, rd_pend flops, pin muxing.
// TESTING (bench uses behavioural fakeram7_dp_512x32 model with per-port we)
//  1. Write A addr 0x010 data 0xDEADBEEF strb 4'hF, then read A 0x010 -> rsp_rdata_A=0xDEADBEEF exactly 2 cycles after read accept.
//  2. Write 0x020=0xFFFFFFFF, then write 0x020 data 0x00000000 strb 4'b0101, read -> 0xFF00FF00.
//  3. Same cycle A write 0x005, B read 0x005 -> req_ready_B=0 first cycle; B accepted next cycle, returns A's data.
//  4. A,B read 0x1FF simultaneously -> both accepted, both respond in the same cycle with equal data.
//  5. rsp_ready_A=0, stream reads on A -> exactly 3 accepted, then req_ready_A=0; release -> 3 in-order responses, throughput 1/cycle resumes.
//  6. rst_n low 1 cycle after a read accept -> no rsp_valid after release, ram_ce_in=0 while idle.

Source files
------------

// File: rtl/fakeram7_ctrl_pkg.sv
// Shared helpers for the fakeram7 dual-port request controller.
// Holds the default macro geometry, the strobe-to-mask expansion and the credit counter width.
package fakeram7_ctrl_pkg;

    localparam int BITS_DEF       = 32;
    localparam int WORD_DEPTH_DEF = 512;
    localparam int ADDR_WIDTH_DEF = 9;
    localparam int RSP_DEPTH_DEF  = 3;

    // Width able to hold 0..depth inclusive.
    function automatic int rsp_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One byte strobe becomes eight bit-mask lanes.
    function automatic logic [7:0] strb2mask(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/fakeram7_rsp_fifo.sv
// Small per-port read response FIFO.
// Occupancy is exported so the top level can compute read credits.
module fakeram7_rsp_fifo
    import fakeram7_ctrl_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic [BITS-1:0]             wdata_i,
    input  logic                        pop_i,
    output logic [BITS-1:0]             rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [rsp_cnt_w(DEPTH)-1:0] count_o
);

    localparam int CNT_W = rsp_cnt_w(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BITS-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && empty_o));

endmodule

// File: rtl/fakeram7_dp_512x32_ctrl.sv
// Request-side controller for the fakeram7_dp_512x32 dual-port macro.
// Drives macro pins from accepted requests, blocks B on write-involved address conflicts, and buffers reads.
module fakeram7_dp_512x32_ctrl
    import fakeram7_ctrl_pkg::*;
#(
    parameter int BITS       = BITS_DEF,
    parameter int WORD_DEPTH = WORD_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid_A,
    output logic                  req_ready_A,
    input  logic                  req_we_A,
    input  logic [ADDR_WIDTH-1:0] req_addr_A,
    input  logic [BITS-1:0]       req_wdata_A,
    input  logic [BITS/8-1:0]     req_wstrb_A,
    output logic                  rsp_valid_A,
    input  logic                  rsp_ready_A,
    output logic [BITS-1:0]       rsp_rdata_A,

    input  logic                  req_valid_B,
    output logic                  req_ready_B,
    input  logic                  req_we_B,
    input  logic [ADDR_WIDTH-1:0] req_addr_B,
    input  logic [BITS-1:0]       req_wdata_B,
    input  logic [BITS/8-1:0]     req_wstrb_B,
    output logic                  rsp_valid_B,
    input  logic                  rsp_ready_B,
    output logic [BITS-1:0]       rsp_rdata_B,

    output logic                  ram_ce_in,
    output logic                  ram_we_in_A,
    output logic                  ram_we_in_B,
    output logic [ADDR_WIDTH-1:0] ram_addr_in_A,
    output logic [ADDR_WIDTH-1:0] ram_addr_in_B,
    output logic [BITS-1:0]       ram_wd_in_A,
    output logic [BITS-1:0]       ram_wd_in_B,
    output logic [BITS-1:0]       ram_w_mask_in_A,
    output logic [BITS-1:0]       ram_w_mask_in_B,
    input  logic [BITS-1:0]       ram_rd_out_A,
    input  logic [BITS-1:0]       ram_rd_out_B
);

    localparam int CNT_W = rsp_cnt_w(RSP_DEPTH);
    localparam int NB    = BITS / 8;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    logic             run_q;
    logic             rd_pend_A_q, rd_pend_B_q;
    logic [CNT_W-1:0] fifo_cnt_A, fifo_cnt_B;
    logic [CNT_W:0]   cnt_A, cnt_B;
    logic             credit_A, credit_B;
    logic             acc_A, acc_B, wr_A, wr_B, collide;
    logic             pop_A, pop_B, empty_A, empty_B, full_A, full_B;

    // Pending reads hold a credit until they land in the FIFO.
    assign cnt_A    = {1'b0, fifo_cnt_A} + (CNT_W+1)'(rd_pend_A_q);
    assign cnt_B    = {1'b0, fifo_cnt_B} + (CNT_W+1)'(rd_pend_B_q);
    assign credit_A = (cnt_A < (CNT_W+1)'(RSP_DEPTH));
    assign credit_B = (cnt_B < (CNT_W+1)'(RSP_DEPTH));

    assign collide = acc_A & req_valid_B & (req_addr_A == req_addr_B) & (req_we_A | req_we_B);

    assign req_ready_A = run_q & (req_we_A | credit_A);
    assign req_ready_B = run_q & (req_we_B | credit_B) & ~collide;
    assign acc_A       = req_valid_A & req_ready_A;
    assign acc_B       = req_valid_B & req_ready_B;
    assign wr_A        = acc_A & req_we_A;
    assign wr_B        = acc_B & req_we_B;

    assign ram_ce_in     = acc_A | acc_B;
    assign ram_we_in_A   = wr_A;
    assign ram_we_in_B   = wr_B;
    assign ram_addr_in_A = acc_A ? req_addr_A : '0;
    assign ram_addr_in_B = acc_B ? req_addr_B : '0;
    assign ram_wd_in_A   = acc_A ? req_wdata_A : '0;
    assign ram_wd_in_B   = acc_B ? req_wdata_B : '0;

    for (genvar i = 0; i < NB; i++) begin : g_mask
        assign ram_w_mask_in_A[8*i +: 8] = strb2mask(wr_A & req_wstrb_A[i]);
        assign ram_w_mask_in_B[8*i +: 8] = strb2mask(wr_B & req_wstrb_B[i]);
    end

    // run_q gives a synchronous release so no request is taken during or on the reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            rd_pend_A_q <= 1'b0;
            rd_pend_B_q <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            rd_pend_A_q <= acc_A & ~req_we_A;
            rd_pend_B_q <= acc_B & ~req_we_B;
        end
    end

    assign rsp_valid_A = ~empty_A;
    assign rsp_valid_B = ~empty_B;
    assign pop_A       = rsp_valid_A & rsp_ready_A;
    assign pop_B       = rsp_valid_B & rsp_ready_B;

    fakeram7_rsp_fifo #(.BITS(BITS), .DEPTH(RSP_DEPTH)) u_rsp_fifo_A (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_pend_A_q),
        .wdata_i (ram_rd_out_A),
        .pop_i   (pop_A),
        .rdata_o (rsp_rdata_A),
        .full_o  (full_A),
        .empty_o (empty_A),
        .count_o (fifo_cnt_A)
    );

    fakeram7_rsp_fifo #(.BITS(BITS), .DEPTH(RSP_DEPTH)) u_rsp_fifo_B (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_pend_B_q),
        .wdata_i (ram_rd_out_B),
        .pop_i   (pop_B),
        .rdata_o (rsp_rdata_B),
        .full_o  (full_B),
        .empty_o (empty_B),
        .count_o (fifo_cnt_B)
    );

    a_cnt_A_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_A <= (CNT_W+1)'(RSP_DEPTH));
    a_cnt_B_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_B <= (CNT_W+1)'(RSP_DEPTH));
    a_push_room_A: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_pend_A_q && full_A && !pop_A));
    a_push_room_B: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_pend_B_q && full_B && !pop_B));
    a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
        (acc_A |-> req_addr_A <= MAX_ADDR) and (acc_B |-> req_addr_B <= MAX_ADDR));

endmodule

// File: tb/tb_fakeram7_dp_512x32_ctrl.sv
// Directed bench for fakeram7_dp_512x32_ctrl with a behavioural dual-port macro model.
module tb_fakeram7_dp_512x32_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_A, req_ready_A, req_we_A, rsp_valid_A, rsp_ready_A;
    logic        req_valid_B, req_ready_B, req_we_B, rsp_valid_B, rsp_ready_B;
    logic [8:0]  req_addr_A, req_addr_B, ram_addr_in_A, ram_addr_in_B;
    logic [31:0] req_wdata_A, req_wdata_B, rsp_rdata_A, rsp_rdata_B;
    logic [3:0]  req_wstrb_A, req_wstrb_B;
    logic        ram_ce_in, ram_we_in_A, ram_we_in_B;
    logic [31:0] ram_wd_in_A, ram_wd_in_B, ram_w_mask_in_A, ram_w_mask_in_B;
    logic [31:0] ram_rd_out_A, ram_rd_out_B;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fakeram7_dp_512x32_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_A(req_valid_A), .req_ready_A(req_ready_A), .req_we_A(req_we_A),
        .req_addr_A(req_addr_A), .req_wdata_A(req_wdata_A), .req_wstrb_A(req_wstrb_A),
        .rsp_valid_A(rsp_valid_A), .rsp_ready_A(rsp_ready_A), .rsp_rdata_A(rsp_rdata_A),
        .req_valid_B(req_valid_B), .req_ready_B(req_ready_B), .req_we_B(req_we_B),
        .req_addr_B(req_addr_B), .req_wdata_B(req_wdata_B), .req_wstrb_B(req_wstrb_B),
        .rsp_valid_B(rsp_valid_B), .rsp_ready_B(rsp_ready_B), .rsp_rdata_B(rsp_rdata_B),
        .ram_ce_in(ram_ce_in), .ram_we_in_A(ram_we_in_A), .ram_we_in_B(ram_we_in_B),
        .ram_addr_in_A(ram_addr_in_A), .ram_addr_in_B(ram_addr_in_B),
        .ram_wd_in_A(ram_wd_in_A), .ram_wd_in_B(ram_wd_in_B),
        .ram_w_mask_in_A(ram_w_mask_in_A), .ram_w_mask_in_B(ram_w_mask_in_B),
        .ram_rd_out_A(ram_rd_out_A), .ram_rd_out_B(ram_rd_out_B)
    );

    // Macro model: masked writes, registered reads returning pre-edge contents.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (ram_ce_in) begin
            if (ram_we_in_A)
                mem[ram_addr_in_A] <= (mem[ram_addr_in_A] & ~ram_w_mask_in_A) | (ram_wd_in_A & ram_w_mask_in_A);
            else
                ram_rd_out_A <= mem[ram_addr_in_A];
            if (ram_we_in_B)
                mem[ram_addr_in_B] <= (mem[ram_addr_in_B] & ~ram_w_mask_in_B) | (ram_wd_in_B & ram_w_mask_in_B);
            else
                ram_rd_out_B <= mem[ram_addr_in_B];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [8:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid_A = v; req_we_A = we; req_addr_A = a; req_wdata_A = d; req_wstrb_A = s;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [8:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid_B = v; req_we_B = we; req_addr_B = a; req_wdata_B = d; req_wstrb_B = s;
    endtask

    // Waits a bounded number of cycles for a response on A, checks it, then steps past its pop edge.
    task automatic wait_rsp_a(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid_A) begin
                chk(tag, rsp_rdata_A, exp);
                tick();
                return;
            end
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp_b(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid_B) begin
                chk(tag, rsp_rdata_B, exp);
                tick();
                return;
            end
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [8:0]  t5_addr [4];
    logic [31:0] t5_data [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, idx, n_rdy;
        logic got;
        t5_addr = '{9'h010, 9'h020, 9'h005, 9'h1FF};
        t5_data = '{32'hDEADBEEF, 32'hFF00FF00, 32'h12345678, 32'hCAFEF00D};
        rsp_ready_A = 1'b1;
        rsp_ready_B = 1'b1;
        drive_a(1'b1, 1'b1, 9'h010, 32'h1111_1111, 4'hF);
        drive_b(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);

        // Reset: pins stay quiet even with a valid request presented.
        repeat (2) @(negedge clk);
        chk("rst_ce", 32'(ram_ce_in), 32'd0);
        chk("rst_ready_a", 32'(req_ready_A), 32'd0);
        chk("rst_addr_a", 32'(ram_addr_in_A), 32'd0);
        chk("rst_mask_a", ram_w_mask_in_A, 32'd0);
        chk("rst_rsp_valid_a", 32'(rsp_valid_A), 32'd0);
        chk("rst_rsp_valid_b", 32'(rsp_valid_B), 32'd0);
        drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: full write then read, 2-cycle latency
        drive_a(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("t1_wr_ready", 32'(req_ready_A), 32'd1);
        chk("t1_wr_we", 32'(ram_we_in_A), 32'd1);
        chk("t1_wr_mask", ram_w_mask_in_A, 32'hFFFFFFFF);
        tick();
        drive_a(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_rd_ready", 32'(req_ready_A), 32'd1);
        chk("t1_rd_we", 32'(ram_we_in_A), 32'd0);
        chk("t1_rd_mask", ram_w_mask_in_A, 32'd0);
        tick();
        drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_lat1_valid", 32'(rsp_valid_A), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_lat2_valid", 32'(rsp_valid_A), 32'd1);
        chk("t1_lat2_data", rsp_rdata_A, 32'hDEADBEEF);
        tick();

        // 2: byte-strobed write
        drive_a(1'b1, 1'b1, 9'h020, 32'hFFFFFFFF, 4'hF);
        tick();
        drive_a(1'b1, 1'b1, 9'h020, 32'h00000000, 4'b0101);
        @(negedge clk);
        chk("t2_mask_0101", ram_w_mask_in_A, 32'h00FF00FF);
        tick();
        drive_a(1'b1, 1'b1, 9'h020, 32'h00000000, 4'b0000);
        @(negedge clk);
        chk("t2_mask_zero", ram_w_mask_in_A, 32'd0);
        chk("t2_ce_zero_strb", 32'(ram_ce_in), 32'd1);
        tick();
        drive_a(1'b1, 1'b0, 9'h020, 32'h0, 4'h0);
        tick();
        drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        wait_rsp_a("t2_rd", 32'hFF00FF00);

        // 3: A write vs B read, same address
        drive_a(1'b1, 1'b1, 9'h005, 32'h12345678, 4'hF);
        drive_b(1'b1, 1'b0, 9'h005, 32'h0, 4'h0);
        @(negedge clk);
        chk("t3_ready_a", 32'(req_ready_A), 32'd1);
        chk("t3_ready_b_blocked", 32'(req_ready_B), 32'd0);
        tick();
        drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("t3_ready_b_retry", 32'(req_ready_B), 32'd1);
        tick();
        drive_b(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        wait_rsp_b("t3_rd_b", 32'h12345678);

        // 4: simultaneous reads, same address
        drive_a(1'b1, 1'b1, 9'h1FF, 32'hCAFEF00D, 4'hF);
        tick();
        drive_a(1'b1, 1'b0, 9'h1FF, 32'h0, 4'h0);
        drive_b(1'b1, 1'b0, 9'h1FF, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4_ready_a", 32'(req_ready_A), 32'd1);
        chk("t4_ready_b", 32'(req_ready_B), 32'd1);
        tick();
        drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        drive_b(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        tick();
        @(negedge clk);
        chk("t4_valid_a", 32'(rsp_valid_A), 32'd1);
        chk("t4_valid_b", 32'(rsp_valid_B), 32'd1);
        chk("t4_data_a", rsp_rdata_A, 32'hCAFEF00D);
        chk("t4_data_b", rsp_rdata_B, 32'hCAFEF00D);
        tick();

        // 5: backpressure caps A at three outstanding reads
        rsp_ready_A = 1'b0;
        idx = 0;
        n_acc = 0;
        drive_a(1'b1, 1'b0, t5_addr[0], 32'h0, 4'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got = req_ready_A;
            if (got) n_acc++;
            tick();
            if (got && idx < 3) begin
                idx++;
                drive_a(1'b1, 1'b0, t5_addr[idx], 32'h0, 4'h0);
            end
        end
        chk("t5_accepted", 32'(n_acc), 32'd3);
        @(negedge clk);
        chk("t5_ready_stalled", 32'(req_ready_A), 32'd0);
        tick();
        drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        rsp_ready_A = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_drain_valid", 32'(rsp_valid_A), 32'd1);
            chk("t5_drain_data", rsp_rdata_A, t5_data[k]);
        end
        tick();
        n_rdy = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    drive_a(1'b1, 1'b0, t5_addr[k], 32'h0, 4'h0);
                    @(negedge clk);
                    if (req_ready_A) n_rdy++;
                    tick();
                end
                drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
            end
            begin
                for (int k = 0; k < 4; k++) wait_rsp_a("t5_stream_data", t5_data[k]);
            end
        join
        chk("t5_stream_ready", 32'(n_rdy), 32'd4);
        tick();

        // 6: reset right after a read accept drops it
        drive_a(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_rd_ready", 32'(req_ready_A), 32'd1);
        tick();
        drive_a(1'b0, 1'b0, 9'h000, 32'h0, 4'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(rsp_valid_A), 32'd0);
            chk("t6_ce_idle", 32'(ram_ce_in), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
